// File: rtl/uart_rx.sv
// UART receiver: start-edge aligned bit timing, LSB-first data, optional parity,
// stop-bit check, and a valid/ready handshake toward the host side.
module uart_rx #(
  parameter int DataBits   = 8,
  parameter int ParityEn   = 0,
  parameter int ParityOdd  = 0,
  parameter int SyncStages = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [15:0]         i_scaler,
  input  logic                i_rx,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_parity_err,
  output logic                o_frame_err,
  output logic                o_overrun,
  output logic                o_busy
);

  localparam int IdxW = $clog2(DataBits + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [SyncStages-1:0] sync;
  logic                  prev;
  logic                  line;
  logic [15:0]           cnt;
  logic [15:0]           s_l;
  logic [IdxW-1:0]       bit_idx;
  logic [DataBits-1:0]   shift;
  logic                  perr;

  assign line   = sync[SyncStages-1];
  assign o_busy = (state != IDLE);

  // Synchronizer and previous-line register idle high so reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SyncStages-2:0], i_rx};
      prev <= line;
    end
  end

  // Receive FSM; the bit counter restarts on each start edge so sampling is frame-aligned.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      s_l          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      perr         <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (!i_en) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (prev && !line) begin
              state   <= START;
              s_l     <= i_scaler;
              bit_idx <= '0;
            end
          end

          START: begin
            if (cnt == (s_l >> 1)) begin
              cnt   <= '0;
              state <= line ? IDLE : DATA;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end

          DATA: begin
            if (cnt == s_l - 16'd1) begin
              cnt   <= '0;
              shift <= {line, shift[DataBits-1:1]};
              if (bit_idx == IdxW'(DataBits - 1)) begin
                bit_idx <= '0;
                state   <= (ParityEn != 0) ? PARITY : STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end

          PARITY: begin
            if (cnt == s_l - 16'd1) begin
              cnt   <= '0;
              perr  <= (((^shift) ^ line) != (ParityOdd != 0));
              state <= STOP;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end

          STOP: begin
            if (cnt == s_l - 16'd1) begin
              cnt   <= '0;
              state <= IDLE;
              // An accept in this same cycle frees the holding register for the new word.
              if (line) begin
                if (!o_valid || i_ready) begin
                  o_data       <= shift;
                  o_parity_err <= (ParityEn != 0) && perr;
                  o_valid      <= 1'b1;
                end else begin
                  o_overrun <= 1'b1;
                end
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, both at 16 clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic       rx_p = 1'b1;
  logic       ready_p = 1'b0;
  logic [7:0] data_p;
  logic       valid_p;
  logic       parity_err_p;
  logic       frame_err_p;
  logic       overrun_p;
  logic       busy_p;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int t0_last = 0;
  int vrise_last = 0;
  int vrise_cnt = 0;
  int vhi_cnt = 0;
  int busy_hi_cnt = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic busy_q = 1'b0;
  logic valid_q = 1'b0;

  int s_vrise, s_vhi, s_busy, s_start, s_ferr, s_ovr;

  uart_rx #(.DataBits(8), .ParityEn(0), .ParityOdd(0), .SyncStages(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_scaler(16'd16), .i_rx(rx),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_parity_err(parity_err),
    .o_frame_err(frame_err), .o_overrun(overrun), .o_busy(busy)
  );

  uart_rx #(.DataBits(8), .ParityEn(1), .ParityOdd(0), .SyncStages(2)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_scaler(16'd16), .i_rx(rx_p),
    .o_data(data_p), .o_valid(valid_p), .i_ready(ready_p), .o_parity_err(parity_err_p),
    .o_frame_err(frame_err_p), .o_overrun(overrun_p), .o_busy(busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder for the 8N1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (busy && !busy_q) begin
      t0_last = cyc;
      start_cnt++;
    end
    if (valid && !valid_q) begin
      vrise_last = cyc;
      vrise_cnt++;
    end
    if (valid)     vhi_cnt++;
    if (busy)      busy_hi_cnt++;
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
    busy_q  = busy;
    valid_q = valid;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives nbits of pat LSB first, 16 clocks per bit, onto one of the two lines.
  task automatic apply_stimulus(input bit to_par, input int nbits, input logic [15:0] pat);
    for (int i = 0; i < nbits; i++) begin
      if (to_par) rx_p = pat[i];
      else        rx   = pat[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snapshot();
    s_vrise = vrise_cnt;
    s_vhi   = vhi_cnt;
    s_busy  = busy_hi_cnt;
    s_start = start_cnt;
    s_ferr  = ferr_cnt;
    s_ovr   = ovr_cnt;
  endtask

  initial begin
    $display("[TB] uart_rx directed test start");
    rst_n = 1'b0;
    wait_cycles(4);
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_data", 32'(data), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(10);

    // 0x55 8N1 with the consumer always ready.
    snapshot();
    apply_stimulus(1'b0, 10, {6'b0, 1'b1, 8'h55, 1'b0});
    wait_cycles(10);
    check_output("t1_latency", 32'(vrise_last - t0_last), 32'd153);
    check_output("t1_valid_cycles", 32'(vhi_cnt - s_vhi), 32'd1);
    check_output("t1_data", 32'(data), 32'h55);
    check_output("t1_perr", 32'(parity_err), 32'd0);
    check_output("t1_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

    // Four-cycle low glitch must be rejected at the mid-start sample.
    snapshot();
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(30);
    check_output("t2_no_valid", 32'(vrise_cnt - s_vrise), 32'd0);
    check_output("t2_starts", 32'(start_cnt - s_start), 32'd1);
    check_output("t2_busy_le9", 32'((busy_hi_cnt - s_busy) <= 9 && (busy_hi_cnt - s_busy) > 0), 32'd1);
    check_output("t2_idle", 32'(busy), 32'd0);

    // 0xA3 with a low stop bit, then the line stays low.
    snapshot();
    apply_stimulus(1'b0, 10, {6'b0, 1'b0, 8'hA3, 1'b0});
    wait_cycles(40);
    rx = 1'b1;
    wait_cycles(30);
    check_output("t3_ferr_pulse", 32'(ferr_cnt - s_ferr), 32'd1);
    check_output("t3_no_valid", 32'(vrise_cnt - s_vrise), 32'd0);
    check_output("t3_no_retrigger", 32'(start_cnt - s_start), 32'd1);
    check_output("t3_data_kept", 32'(data), 32'h55);

    // Consumer stalled: second frame overruns and the first word is kept.
    ready = 1'b0;
    snapshot();
    apply_stimulus(1'b0, 10, {6'b0, 1'b1, 8'h12, 1'b0});
    wait_cycles(20);
    check_output("t4_valid1", 32'(valid), 32'd1);
    check_output("t4_data1", 32'(data), 32'h12);
    apply_stimulus(1'b0, 10, {6'b0, 1'b1, 8'h34, 1'b0});
    wait_cycles(20);
    check_output("t4_overrun", 32'(ovr_cnt - s_ovr), 32'd1);
    check_output("t4_data_kept", 32'(data), 32'h12);
    check_output("t4_valid_held", 32'(valid), 32'd1);
    check_output("t4_one_delivery", 32'(vrise_cnt - s_vrise), 32'd1);
    ready = 1'b1;
    wait_cycles(1);
    check_output("t4_accept", 32'(valid), 32'd0);

    // Even parity instance: 0x07 has three ones, so parity 0 is wrong.
    apply_stimulus(1'b1, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0});
    wait_cycles(20);
    check_output("t5_valid", 32'(valid_p), 32'd1);
    check_output("t5_data", 32'(data_p), 32'h07);
    check_output("t5_perr", 32'(parity_err_p), 32'd1);
    check_output("t5_ferr", 32'(frame_err_p), 32'd0);
    ready_p = 1'b1;
    wait_cycles(2);
    ready_p = 1'b0;
    check_output("t5_accept", 32'(valid_p), 32'd0);
    apply_stimulus(1'b1, 11, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0});
    wait_cycles(20);
    check_output("t5b_data", 32'(data_p), 32'h03);
    check_output("t5b_perr", 32'(parity_err_p), 32'd0);

    // Reset in the middle of the data bits, then a clean 0x5A frame.
    ready = 1'b0;
    wait_cycles(2);
    ready = 1'b1;
    apply_stimulus(1'b0, 4, 16'b1010);
    #1;
    check_output("t6_mid_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    rst_n = 1'b0;
    wait_cycles(2);
    check_output("t6_rst_busy", 32'(busy), 32'd0);
    check_output("t6_rst_valid", 32'(valid), 32'd0);
    check_output("t6_rst_data", 32'(data), 32'd0);
    check_output("t6_rst_pdata", 32'(data_p), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);
    snapshot();
    apply_stimulus(1'b0, 10, {6'b0, 1'b1, 8'h5A, 1'b0});
    wait_cycles(10);
    check_output("t6_delivered", 32'(vrise_cnt - s_vrise), 32'd1);
    check_output("t6_data", 32'(data), 32'h5A);
    check_output("t6_latency", 32'(vrise_last - t0_last), 32'd153);
    check_output("t6_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
